// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/piso_shift_tx_bit_counter.sv
// Bit-position counter: synchronous clear wins over enable; tc flags the last position.
module piso_shift_tx_bit_counter #(
  parameter int CNT_W = 3,
  parameter int LAST  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)   cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/piso_shift_tx.sv
// Serialises a WIDTH-bit word one bit per shift_en strobe, with sof/frame_done framing.
// A new word can be accepted on the last-bit strobe, so frames run back to back gaplessly.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             sof,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sdo_q, sdo_d;
  logic             busy_q, busy_d;
  logic             sof_q, sof_d;
  logic             frame_done_q, frame_done_d;

  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             shift_now, last_shift, accept, cnt_clr, cnt_en;

  assign shift_now  = (state_q == SHIFT) && shift_en;
  assign last_shift = shift_now && tc;
  assign load_ready = (state_q == IDLE) || last_shift;
  assign accept     = load_valid && load_ready;
  assign cnt_clr    = accept || last_shift;
  assign cnt_en     = shift_now && !tc;

  piso_shift_tx_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (WIDTH - 1)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = load_data;
    end else if (last_shift) begin
      state_d = IDLE;
      shreg_d = '0;
    end else if (shift_now) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
    end
    // Outputs are computed from next state so they are registered yet aligned with it.
    busy_d       = (state_d == SHIFT);
    sdo_d        = busy_d && (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
    sof_d        = busy_d && (cnt_clr || ((cnt == '0) && !cnt_en));
    frame_done_d = last_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      sdo_q        <= 1'b0;
      busy_q       <= 1'b0;
      sof_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      sdo_q        <= sdo_d;
      busy_q       <= busy_d;
      sof_q        <= sof_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sdo        = sdo_q;
  assign sdo_valid  = busy_q;
  assign busy       = busy_q;
  assign sof        = sof_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a word/bit-index reference model.
module tb_piso_shift_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         shift_en;

  logic rdy_m, sdo_m, vld_m, sof_m, fd_m, busy_m;
  logic rdy_l, sdo_l, vld_l, sof_l, fd_l, busy_l;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: which word is on the line and which bit position is being sent.
  bit         m_active;
  logic [W-1:0] m_word;
  int         m_idx;
  bit         m_fd;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_m),
    .load_data(load_data), .shift_en(shift_en), .sdo(sdo_m), .sdo_valid(vld_m),
    .sof(sof_m), .frame_done(fd_m), .busy(busy_m)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_l),
    .load_data(load_data), .shift_en(shift_en), .sdo(sdo_l), .sdo_valid(vld_l),
    .sof(sof_l), .frame_done(fd_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready(input bit se);
    return !m_active || (m_idx == W - 1 && se);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_word   = '0;
    m_idx    = 0;
    m_fd     = 1'b0;
  endtask

  task automatic check_outputs();
    logic exp_m, exp_l;
    exp_m = m_active ? m_word[W-1-m_idx] : 1'b0;
    exp_l = m_active ? m_word[m_idx]     : 1'b0;
    chk("sdo_msb",   sdo_m,  exp_m);
    chk("sdo_lsb",   sdo_l,  exp_l);
    chk("sdo_valid", vld_m,  m_active);
    chk("busy",      busy_m, m_active);
    chk("sof",       sof_m,  m_active && m_idx == 0);
    chk("frame_done", fd_m,  m_fd);
    chk("lsb_ctrl",  {vld_l, busy_l, sof_l, fd_l}, {vld_m, busy_m, sof_m, fd_m});
  endtask

  // Called at posedge+1; returns at the following posedge+1 with outputs checked.
  task automatic cycle(input logic lv, input logic [W-1:0] d, input logic se);
    bit acc, fdn;
    load_valid = lv;
    load_data  = d;
    shift_en   = se;
    #3;
    chk("load_ready",     rdy_m, m_ready(se));
    chk("load_ready_lsb", rdy_l, m_ready(se));
    acc = lv && m_ready(se);
    fdn = m_active && (m_idx == W - 1) && se;
    @(posedge clk);
    if (acc) begin
      m_active = 1'b1;
      m_word   = d;
      m_idx    = 0;
    end else if (m_active && se) begin
      if (m_idx == W - 1) m_active = 1'b0;
      else                m_idx++;
    end
    m_fd = fdn;
    #1;
    check_outputs();
  endtask

  initial begin
    logic [W-1:0] bits;
    int n_vld, n_both, n_busy, n_fd;

    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    shift_en   = 1'b0;
    model_reset();

    // Reset held with random inputs: everything stays cleared.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      load_valid = 1'($urandom);
      load_data  = W'($urandom);
      shift_en   = 1'($urandom);
      check_outputs();
    end
    reset = 1'b1;

    // Single frame 0xA5 MSB first.
    bits = '0;
    cycle(1'b1, 8'hA5, 1'b1);
    bits = {bits[W-2:0], sdo_m};
    for (int i = 0; i < W - 1; i++) begin
      cycle(1'b0, '0, 1'b1);
      bits = {bits[W-2:0], sdo_m};
    end
    chk("a5_serial", bits, 8'hA5);
    cycle(1'b0, '0, 1'b1);
    chk("a5_done", fd_m, 1'b1);
    chk("a5_idle", vld_m, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // Back-to-back 0xA5 then 0x3C with load_valid held.
    n_vld  = 0;
    n_both = 0;
    cycle(1'b1, 8'hA5, 1'b1);
    n_vld += vld_m;
    for (int i = 0; i < 15; i++) begin
      cycle(i < 8, 8'h3C, 1'b1);
      n_vld  += vld_m;
      n_both += (sof_m && fd_m);
    end
    chk("b2b_valid_bits", n_vld, 16);
    chk("b2b_sof_and_done", n_both, 1);
    cycle(1'b0, '0, 1'b1);
    chk("b2b_done", fd_m, 1'b1);

    // Throttled: shift strobe every third cycle.
    cycle(1'b1, 8'hF0, 1'b0);
    n_busy = busy_m;
    n_fd   = 0;
    for (int i = 0; i < 27; i++) begin
      cycle(1'b0, '0, (i % 3) == 2);
      n_busy += busy_m;
      n_fd   += fd_m;
    end
    chk("thr_busy_cycles", n_busy, 24);
    chk("thr_done_count", n_fd, 1);

    // LSB first 0x01.
    bits = '0;
    cycle(1'b1, 8'h01, 1'b1);
    bits = {bits[W-2:0], sdo_l};
    for (int i = 0; i < W - 1; i++) begin
      cycle(1'b0, '0, 1'b1);
      bits = {bits[W-2:0], sdo_l};
    end
    chk("lsb_serial", bits, 8'h80);
    cycle(1'b0, '0, 1'b1);

    // Abort 0xFF after three bits, then a clean 0x80 frame.
    cycle(1'b1, 8'hFF, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;
    n_fd = 0;
    cycle(1'b1, 8'h80, 1'b1);
    for (int i = 0; i < W; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_fd += fd_m;
    end
    chk("abort_next_done", n_fd, 1);

    // load_valid held mid-frame with changing data offered.
    cycle(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b1, W'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
